serial_word_serializer: RTL and testbench
=========================================

SERIAL_WORD_SERIALIZER -- requirements
Module: serial_word_serializer

Interface
REQ-001 The block SHALL have parameter: w, 16, maximum word width in bits (w >= 2).
REQ-002 The block SHALL have port: clk  input  1  single clock; all state updates on the rising edge.
REQ-003 The block SHALL have port: rst  input  1  synchronous, active-high reset.
REQ-004 The block SHALL have port: in_valid  input  1  upstream word available.
REQ-005 The block SHALL have port: in_ready  output  1  block accepts a word this cycle.
REQ-006 The block SHALL have port: in_data  input  w  word; bits [len-1:0] are significant.
REQ-007 The block SHALL have port: in_len  input  $clog2(w+1)  significant-bit count; 0 or >w means w.
REQ-008 The block SHALL have port: out_valid  output  1  new_bit is valid.
REQ-009 The block SHALL have port: out_ready  input  1  downstream accepts the bit; tie to 1 for the free-running divisibility FSMs.
REQ-010 The block SHALL have port: new_bit  output  1  current serial bit, MSB-first.
REQ-011 The block SHALL have port: first  output  1  current bit is the first of a word; downstream clears its remainder.
REQ-012 The block SHALL have port: last  output  1  current bit is the last of a word.

Function
REQ-013 The block SHALL transfer a word when in_valid && in_ready at a rising edge, and a bit when out_valid && out_ready at a rising edge.
REQ-014 The block SHALL implement a two-state FSM: IDLE (no word held) and SHIFT (word held, out_valid=1).
REQ-015 In IDLE, the block SHALL drive in_ready=1 and out_valid=0; new_bit, first and last SHALL be 0.
REQ-016 IDLE SHALL go to SHIFT on a word transfer; SHIFT SHALL go to IDLE on transfer of the last bit with no simultaneous word transfer.
REQ-017 In SHIFT, the block SHALL drive in_ready = out_ready && last, giving zero-bubble back-to-back words.
REQ-018 On a word transfer, the block SHALL capture in_data and the effective length L (L = w when in_len is 0 or >w) and load a bit counter with L-1.
REQ-019 The first bit SHALL be presented in the cycle after the word transfer edge (latency 1) with first=1 and new_bit=in_data[L-1].
REQ-020 On each bit transfer, the block SHALL advance to the next lower bit and decrement the counter; first SHALL be 1 only on bit L-1, and last SHALL be 1 only when the counter is 0.
REQ-021 When L=1, the block SHALL assert first and last on the same single beat.
REQ-022 While out_valid=1 and out_ready=0, new_bit, first, last and out_valid SHALL hold stable, and no word SHALL be accepted.
REQ-023 On a simultaneous last-bit transfer and word transfer, the block SHALL present the new word's first bit in the next cycle, with no idle cycle.
REQ-024 Bits of in_data above L-1 SHALL be ignored, and in_data/in_len SHALL be sampled only at the word transfer edge.
REQ-025 All outputs except in_ready SHALL be driven from registers; in_ready SHALL be combinational from state, last and out_ready only, never from in_valid.

Reset
REQ-026 While rst=1 at a rising edge, the block SHALL enter IDLE with out_valid=0, new_bit=0, first=0, last=0 and counter=0.
REQ-027 During the cycle rst=1, the block SHALL drive in_ready=0 and SHALL accept no word.
REQ-028 Reset mid-word SHALL discard the remaining bits, and the cycle after rst deasserts SHALL show IDLE values with in_ready=1.
REQ-029 When rst=x, the block SHALL drive no non-x outputs.

Verification
REQ-030 w=16, in_data=16'hA5C3, in_len=0, out_ready=1 -> 16 consecutive beats 1010010111000011; first on beat 1 only, last on beat 16 only.
REQ-031 in_data=16'hFFF5, in_len=3 -> beats 1,0,1; first on beat 1, last on beat 3; then IDLE with in_ready=1.
REQ-032 in_len=1, in_data=16'h0001 -> a single beat with new_bit=1, first=1, last=1.
REQ-033 Two words 16'h0003 (len 2) and 16'h0005 (len 3) with in_valid held high -> beats 1,1,1,0,1 with no gap; first on beats 1 and 3, last on beats 2 and 5.
REQ-034 out_ready=0 for 3 cycles in mid-word -> outputs held constant for those cycles, in_ready=0, and the sequence resumes unchanged.
REQ-035 rst pulsed on beat 5 of a 16-bit word -> out_valid=0 the following cycle; the next word starts with first=1 at its MSB.
REQ-036 Random 16-bit words feeding the serial divisibility-by-3 and divisibility-by-5 FSMs with out_ready=1 -> their flags on last match word%3==0 and word%5==0.

Source files
------------

// File: rtl/serial_word_serializer.sv
// serial_word_serializer: accepts a word of up to w bits and emits it MSB-first, one bit per beat.
//   clk       in   rising-edge clock
//   rst       in   synchronous active-high reset
//   in_valid  in   upstream word available
//   in_ready  out  word accepted this cycle when in_valid is also high
//   in_data   in   word; bits [L-1:0] are significant
//   in_len    in   significant-bit count L; 0 or greater than w selects w
//   out_valid out  new_bit is valid
//   out_ready in   downstream accepts the current bit
//   new_bit   out  current serial bit, MSB-first
//   first     out  current bit is the first of its word
//   last      out  current bit is the last of its word
module serial_word_serializer #(
    parameter int w = 16
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   in_valid,
    output logic                   in_ready,
    input  logic [w-1:0]           in_data,
    input  logic [$clog2(w+1)-1:0] in_len,
    output logic                   out_valid,
    input  logic                   out_ready,
    output logic                   new_bit,
    output logic                   first,
    output logic                   last
);
    localparam int LW = $clog2(w + 1);
    localparam int CW = $clog2(w);

    typedef enum logic {IDLE = 1'b0, SHIFT = 1'b1} state_t;

    state_t         state_q, state_d;
    logic [w-1:0]   data_q, data_d;
    logic [CW-1:0]  cnt_q, cnt_d, cnt_m1, ld_cnt;
    logic           new_bit_q, new_bit_d;
    logic           first_q, first_d;
    logic           last_q, last_d;
    logic [LW-1:0]  len_eff;
    logic           in_fire, out_fire, bit_done;

    // Zero or oversized lengths fall back to the full word width.
    assign len_eff  = (in_len == '0 || in_len > LW'(w)) ? LW'(w) : in_len;
    assign ld_cnt   = CW'(len_eff - 1'b1);
    assign cnt_m1   = cnt_q - 1'b1;

    // A new word may enter while the last bit of the current one leaves, so
    // back-to-back words stream without a bubble.
    assign in_ready = !rst && (state_q == IDLE || (out_ready && last_q));
    assign in_fire  = in_valid && in_ready;
    assign out_fire = (state_q == SHIFT) && out_ready;
    assign bit_done = out_fire && last_q;

    always_comb begin
        state_d   = in_fire ? SHIFT : bit_done ? IDLE : state_q;
        data_d    = in_fire ? in_data : data_q;
        cnt_d     = in_fire ? ld_cnt : bit_done ? '0 : out_fire ? cnt_m1 : cnt_q;
        new_bit_d = in_fire ? in_data[ld_cnt] : bit_done ? 1'b0 : out_fire ? data_q[cnt_m1] : new_bit_q;
        first_d   = in_fire ? 1'b1 : out_fire ? 1'b0 : first_q;
        last_d    = in_fire ? (ld_cnt == '0) : bit_done ? 1'b0 : out_fire ? (cnt_q == CW'(1)) : last_q;
    end

    // Ternary form lets an unknown rst propagate to the registers.
    always_ff @(posedge clk) begin
        state_q   <= rst ? IDLE : state_d;
        data_q    <= rst ? '0 : data_d;
        cnt_q     <= rst ? '0 : cnt_d;
        new_bit_q <= rst ? 1'b0 : new_bit_d;
        first_q   <= rst ? 1'b0 : first_d;
        last_q    <= rst ? 1'b0 : last_d;
    end

    assign out_valid = (state_q == SHIFT);
    assign new_bit   = new_bit_q;
    assign first     = first_q;
    assign last      = last_q;
endmodule

// File: tb/tb_serial_word_serializer.sv
// tb_serial_word_serializer: directed self-checking bench for serial_word_serializer.
module tb_serial_word_serializer;
    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        in_valid = 1'b0;
    logic        in_ready;
    logic [15:0] in_data = '0;
    logic [4:0]  in_len = '0;
    logic        out_valid;
    logic        out_ready = 1'b1;
    logic        new_bit;
    logic        first;
    logic        last;
    int          checks = 0;
    int          fails = 0;

    serial_word_serializer #(.w(16)) dut (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
        .in_data(in_data), .in_len(in_len), .out_valid(out_valid),
        .out_ready(out_ready), .new_bit(new_bit), .first(first), .last(last)
    );

    always #5 clk = ~clk;

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset;
        rst = 1'b1; in_valid = 1'b1; in_data = 16'hFFFF; in_len = 5'd0;
        tick();
        checks++; if (in_ready !== 1'b0) begin fails++; $display("FAIL reset_in_ready got=%b exp=0", in_ready); end
        checks++; if ({out_valid, new_bit, first, last} !== 4'b0000) begin fails++; $display("FAIL reset_outputs got=%b exp=0000", {out_valid, new_bit, first, last}); end
        rst = 1'b0; in_valid = 1'b0;
        tick();
        checks++; if (out_valid !== 1'b0) begin fails++; $display("FAIL reset_no_accept out_valid got=%b exp=0", out_valid); end
        checks++; if (in_ready !== 1'b1) begin fails++; $display("FAIL idle_in_ready got=%b exp=1", in_ready); end
    endtask

    task automatic test_full_word;
        logic [15:0] wd;
        wd = 16'hA5C3;
        in_valid = 1'b1; in_data = wd; in_len = 5'd0; out_ready = 1'b1;
        tick();
        in_valid = 1'b0;
        for (int i = 0; i < 16; i++) begin
            checks++;
            if ({out_valid, new_bit, first, last} !== {1'b1, wd[15-i], i == 0, i == 15}) begin
                fails++;
                $display("FAIL full_word beat%0d got v/b/f/l=%b exp=%b", i + 1, {out_valid, new_bit, first, last}, {1'b1, wd[15-i], i == 0, i == 15});
            end
            tick();
        end
        checks++; if ({out_valid, in_ready} !== 2'b01) begin fails++; $display("FAIL full_word_idle got v/rdy=%b exp=01", {out_valid, in_ready}); end
    endtask

    task automatic test_short_len;
        logic [2:0] eb;
        eb = 3'b101;
        in_valid = 1'b1; in_data = 16'hFFF5; in_len = 5'd3;
        tick();
        in_valid = 1'b0; in_data = 16'h0000;
        for (int i = 0; i < 3; i++) begin
            checks++;
            if ({out_valid, new_bit, first, last} !== {1'b1, eb[2-i], i == 0, i == 2}) begin
                fails++;
                $display("FAIL short_len beat%0d got v/b/f/l=%b exp=%b", i + 1, {out_valid, new_bit, first, last}, {1'b1, eb[2-i], i == 0, i == 2});
            end
            tick();
        end
        checks++; if ({out_valid, in_ready, new_bit, first, last} !== 5'b01000) begin fails++; $display("FAIL short_len_idle got v/rdy/b/f/l=%b exp=01000", {out_valid, in_ready, new_bit, first, last}); end
    endtask

    task automatic test_len_one;
        in_valid = 1'b1; in_data = 16'h0001; in_len = 5'd1;
        tick();
        in_valid = 1'b0;
        checks++; if ({out_valid, new_bit, first, last} !== 4'b1111) begin fails++; $display("FAIL len_one beat got v/b/f/l=%b exp=1111", {out_valid, new_bit, first, last}); end
        tick();
        checks++; if ({out_valid, in_ready} !== 2'b01) begin fails++; $display("FAIL len_one_idle got v/rdy=%b exp=01", {out_valid, in_ready}); end
    endtask

    task automatic test_back_to_back;
        logic [4:0] eb, ef, el;
        eb = 5'b11101; ef = 5'b10100; el = 5'b01001;
        in_valid = 1'b1; in_data = 16'h0003; in_len = 5'd2;
        tick();
        in_data = 16'h0005; in_len = 5'd3;
        for (int i = 0; i < 5; i++) begin
            checks++;
            if ({out_valid, new_bit, first, last} !== {1'b1, eb[4-i], ef[4-i], el[4-i]}) begin
                fails++;
                $display("FAIL back_to_back beat%0d got v/b/f/l=%b exp=%b", i + 1, {out_valid, new_bit, first, last}, {1'b1, eb[4-i], ef[4-i], el[4-i]});
            end
            if (i < 2) begin
                checks++;
                if (in_ready !== (i == 1)) begin fails++; $display("FAIL back_to_back_rdy beat%0d got=%b exp=%b", i + 1, in_ready, i == 1); end
            end
            tick();
            if (i == 1) in_valid = 1'b0;
        end
        checks++; if (out_valid !== 1'b0) begin fails++; $display("FAIL back_to_back_idle got=%b exp=0", out_valid); end
    endtask

    task automatic test_stall;
        logic [15:0] wd;
        wd = 16'hA5C3;
        in_valid = 1'b1; in_data = wd; in_len = 5'd16; out_ready = 1'b1;
        tick();
        in_valid = 1'b0;
        for (int i = 0; i < 4; i++) tick();
        out_ready = 1'b0; in_valid = 1'b1; in_data = 16'h1234; in_len = 5'd4;
        for (int k = 0; k < 3; k++) begin
            checks++;
            if ({out_valid, new_bit, first, last, in_ready} !== {1'b1, wd[11], 1'b0, 1'b0, 1'b0}) begin
                fails++;
                $display("FAIL stall_hold cyc%0d got v/b/f/l/rdy=%b exp=%b", k, {out_valid, new_bit, first, last, in_ready}, {1'b1, wd[11], 3'b000});
            end
            tick();
        end
        out_ready = 1'b1; in_valid = 1'b0;
        for (int i = 4; i < 16; i++) begin
            checks++;
            if ({out_valid, new_bit, first, last} !== {1'b1, wd[15-i], 1'b0, i == 15}) begin
                fails++;
                $display("FAIL stall_resume beat%0d got v/b/f/l=%b exp=%b", i + 1, {out_valid, new_bit, first, last}, {1'b1, wd[15-i], 1'b0, i == 15});
            end
            tick();
        end
        checks++; if (out_valid !== 1'b0) begin fails++; $display("FAIL stall_end got=%b exp=0", out_valid); end
    endtask

    task automatic test_reset_mid;
        in_valid = 1'b1; in_data = 16'hA5C3; in_len = 5'd0;
        tick();
        in_valid = 1'b0;
        for (int i = 0; i < 4; i++) tick();
        rst = 1'b1;
        #1;
        checks++; if (in_ready !== 1'b0) begin fails++; $display("FAIL rst_mid_rdy got=%b exp=0", in_ready); end
        tick();
        rst = 1'b0;
        #1;
        checks++; if ({out_valid, new_bit, first, last, in_ready} !== 5'b00001) begin fails++; $display("FAIL rst_mid_idle got v/b/f/l/rdy=%b exp=00001", {out_valid, new_bit, first, last, in_ready}); end
        in_valid = 1'b1; in_data = 16'h8001; in_len = 5'd0;
        tick();
        in_valid = 1'b0;
        checks++; if ({out_valid, new_bit, first, last} !== 4'b1110) begin fails++; $display("FAIL rst_mid_next got v/b/f/l=%b exp=1110", {out_valid, new_bit, first, last}); end
        for (int i = 0; i < 16; i++) tick();
    endtask

    task automatic test_divisibility;
        logic [15:0] wd;
        logic [4:0]  lens [4];
        int          r3, r5;
        lens[0] = 5'd0; lens[1] = 5'd16; lens[2] = 5'd17; lens[3] = 5'd31;
        out_ready = 1'b1;
        for (int n = 0; n < 20; n++) begin
            wd = 16'($urandom);
            in_valid = 1'b1; in_data = wd; in_len = lens[n % 4];
            tick();
            in_valid = 1'b0;
            r3 = 0; r5 = 0;
            for (int i = 0; i < 16; i++) begin
                r3 = first ? int'(new_bit) : (2 * r3 + int'(new_bit)) % 3;
                r5 = first ? int'(new_bit) : (2 * r5 + int'(new_bit)) % 5;
                if (out_valid === 1'b1 && last === 1'b1) begin
                    checks++;
                    if (i != 15 || (r3 == 0) != (wd % 3 == 0) || (r5 == 0) != (wd % 5 == 0)) begin
                        fails++;
                        $display("FAIL divisibility word=%h beat=%0d got d3/d5=%0d%0d exp=%0d%0d", wd, i + 1, r3 == 0, r5 == 0, wd % 3 == 0, wd % 5 == 0);
                    end
                end
                tick();
            end
            checks++; if (out_valid !== 1'b0) begin fails++; $display("FAIL divisibility_end word=%h got v=%b exp=0", wd, out_valid); end
        end
    endtask

    initial begin
        test_reset();
        test_full_word();
        test_short_len();
        test_len_one();
        test_back_to_back();
        test_stall();
        test_reset_mid();
        test_divisibility();
        $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
        $finish;
    end
endmodule
